// File: rtl/vdffe_fifo.sv
// vdffe_fifo: parametrised synchronous FIFO with valid/ready handshakes on both sides.
// Storage is a DEPTH x k register array (DEPTH = 2**AW). The read side is a mux on the
// read pointer. Full and empty are derived from the occupancy counter, never from the
// pointers.
// Optional build macro FIFO_BYPASS_EN: when the FIFO is empty, a word offered on the input
// falls through to the output combinationally. If the consumer takes it in that same
// cycle, the word is never written.
module vdffe_fifo #(
    parameter int k  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [k-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [k-1:0]  out_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [k-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push_wr;   // word is written into storage
    logic          pop_rd;    // head word leaves storage

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign in_ready = ~full;

`ifdef FIFO_BYPASS_EN
    logic bypass;
    // An empty FIFO presents the incoming word directly; a same-cycle take skips storage.
    assign bypass    = empty & in_valid & out_ready;
    assign out_valid = ~empty | in_valid;
    assign out_data  = empty ? in_data : mem[rp];
    assign push_wr   = in_valid & in_ready & ~bypass;
    assign pop_rd    = out_ready & ~empty;
`else
    // Base build: output is registered storage only, no combinational in->out path.
    assign out_valid = ~empty;
    assign out_data  = mem[rp];
    assign push_wr   = in_valid & in_ready;
    assign pop_rd    = out_valid & out_ready;
`endif

    // Storage array: written on accepted pushes only, contents are not reset.
    always_ff @(posedge clk) begin
        if (!reset && push_wr)
            mem[wp] <= in_data;
    end

    // Pointers and occupancy; reset discards contents and ignores that edge's handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_wr)
                wp <= wp + AW'(1);
            if (pop_rd)
                rp <= rp + AW'(1);
            case ({push_wr, pop_rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_vdffe_fifo.sv
// tb_vdffe_fifo: scoreboard bench for vdffe_fifo (k=8, AW=2).
// The stimulus process drives its inputs 1 ns after posedge. The monitor samples at negedge
// and compares the DUT against a queue model of the FIFO contents. A word the producer
// offers is appended to the expected queue once it is accepted. The monitor pops that
// queue whenever the consumer takes a word.
module tb_vdffe_fifo;
    localparam int K     = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [K-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [K-1:0]  out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_ok = 1'b0;
    logic [K-1:0] exp_q[$];

    vdffe_fifo #(.k(K), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Set inputs for the next cycle, just after a rising edge.
    task automatic drive(input logic v, input logic [K-1:0] d, input logic r, input logic rs);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        reset     = rs;
    endtask

    // Monitor: compare flags against the model, check the popped word, then advance the model.
    initial begin
        int sz;
        logic [K-1:0] head;
        forever begin
            @(negedge clk);
            sz = exp_q.size();
            if (model_ok) begin
                chk("count", int'(count), sz);
                chk("full", int'(full), int'(sz == DEPTH));
                chk("empty", int'(empty), int'(sz == 0));
                chk("in_ready", int'(in_ready), int'(sz < DEPTH));
`ifdef FIFO_BYPASS_EN
                chk("out_valid", int'(out_valid), int'(sz > 0 || in_valid));
`else
                chk("out_valid", int'(out_valid), int'(sz > 0));
`endif
            end
            if (reset) begin
                exp_q.delete();
                model_ok = 1'b1;
            end else if (model_ok) begin
`ifdef FIFO_BYPASS_EN
                if (sz == 0 && in_valid && out_ready) begin
                    chk("bypass_data", int'(out_data), int'(in_data));
                end else begin
`else
                begin
`endif
                    if (sz > 0 && out_ready) begin
                        head = exp_q.pop_front();
                        chk("out_data", int'(out_data), int'(head));
                    end
                    if (in_valid && sz < DEPTH)
                        exp_q.push_back(in_data);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by constrained-random traffic.
    initial begin
        logic [K-1:0] words[4];
        bit held;
        int rdy_pct;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

        // Reset with a word offered: nothing may be stored.
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, then drain in order.
        for (int i = 0; i < 4; i++) drive(1'b1, words[i], 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Full with push and pop offered together: only the pop happens.
        for (int i = 0; i < 4; i++) drive(1'b1, words[i], 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Steady push+pop at occupancy 1: pointers wrap.
        drive(1'b1, 8'h60, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'h61 + i), 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Mid-operation reset, then a new word must come out first.
        for (int i = 0; i < 3; i++) drive(1'b1, words[i], 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b1);
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Empty with word offered and consumer ready (bypass or one-cycle latency).
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic; producer holds its word while not accepted.
        for (int i = 0; i < 3000; i++) begin
            rdy_pct = ((i / 300) % 2 == 0) ? 25 : 80;
            @(negedge clk);
            held = in_valid && !in_ready && !reset;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (!held) begin
                in_valid = $urandom_range(0, 99) < 60;
                in_data  = K'($urandom);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
